// File: rtl/ysyx_22051013_ex_ctrl_pkg.sv
// Shared execute-stage definitions: FSM state encoding, data width, ALU select codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ysyx_22051013_ex_ctrl_pkg;

    localparam int YSYX_XLEN = 64;
    localparam int SEL_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } ex_state_e;

    // One-hot ALU select codes
    localparam logic [SEL_W-1:0] SEL_ADD = 7'b000_0001;
    localparam logic [SEL_W-1:0] SEL_SUB = 7'b000_0010;
    localparam logic [SEL_W-1:0] SEL_AND = 7'b000_0100;
    localparam logic [SEL_W-1:0] SEL_OR  = 7'b000_1000;
    localparam logic [SEL_W-1:0] SEL_XOR = 7'b001_0000;
    localparam logic [SEL_W-1:0] SEL_SLL = 7'b010_0000;
    localparam logic [SEL_W-1:0] SEL_LUI = 7'b100_0000;

endpackage

// File: rtl/ysyx_22051013_ex_ctrl_if.sv
// Execute-controller bus: decode handshake, ALU operand/result path, writeback handshake, redirect.
// Latency: n/a (wiring only).
// Backpressure: id_ready_o / wb_ready_i carry the valid-ready handshakes.
// Modports: ctrl = the execute controller, env = the surrounding pipeline.
interface ysyx_22051013_ex_ctrl_if
    import ysyx_22051013_ex_ctrl_pkg::*;
#(
    parameter int LAT_W = 4,
    parameter int XLEN  = YSYX_XLEN
) ();

    // decode side
    logic             id_valid_i;
    logic             id_ready_o;
    logic [XLEN-1:0]  id_pc_i;
    logic [XLEN-1:0]  id_op1_i;
    logic [XLEN-1:0]  id_op2_i;
    logic [SEL_W-1:0] id_alu_sel_i;
    logic             id_jump_i;
    logic [LAT_W-1:0] id_lat_i;

    // ALU side
    logic [XLEN-1:0]  alu_pc_o;
    logic [XLEN-1:0]  alu_op1_o;
    logic [XLEN-1:0]  alu_op2_o;
    logic [SEL_W-1:0] alu_sel_o;
    logic             alu_jump_o;
    logic [XLEN-1:0]  alu_res_i;
    logic [XLEN-1:0]  alu_jump_pc_i;
    logic             alu_pcsrc_i;

    // writeback / fetch side
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [XLEN-1:0]  wb_res_o;
    logic             redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             busy_o;

    modport ctrl (
        input  id_valid_i, id_pc_i, id_op1_i, id_op2_i, id_alu_sel_i, id_jump_i, id_lat_i,
        input  alu_res_i, alu_jump_pc_i, alu_pcsrc_i, wb_ready_i,
        output id_ready_o, alu_pc_o, alu_op1_o, alu_op2_o, alu_sel_o, alu_jump_o,
        output wb_valid_o, wb_res_o, redirect_o, redirect_pc_o, busy_o
    );

    modport env (
        output id_valid_i, id_pc_i, id_op1_i, id_op2_i, id_alu_sel_i, id_jump_i, id_lat_i,
        output alu_res_i, alu_jump_pc_i, alu_pcsrc_i, wb_ready_i,
        input  id_ready_o, alu_pc_o, alu_op1_o, alu_op2_o, alu_sel_o, alu_jump_o,
        input  wb_valid_o, wb_res_o, redirect_o, redirect_pc_o, busy_o
    );

endinterface

// File: rtl/ysyx_22051013_ex_lat_cnt.sv
// Extra-latency counter: loads a cycle count, counts down to zero and saturates there.
// Latency: zero flag reflects the registered count (load visible next cycle).
// Backpressure: none; load takes priority over decrement.
// Ports: clk, rst (sync, active-high), load/load_val, dec, zero.
module ysyx_22051013_ex_lat_cnt #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LAT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            // never wraps: a decrement request at zero is ignored
            cnt_q <= cnt_q - LAT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ysyx_22051013_ex_ctrl.sv
// Execute-stage controller: registers an op for the ALU, waits its extra latency, hands result to writeback.
// Latency: op accepted in cycle t with extra latency L gives wb_valid_o in cycle t+L+2.
// Backpressure: result held in DONE while wb_ready_i is low; decode stalls (id_ready_o low) meanwhile.
// Ports: clk, rst (sync, active-high), bus (ysyx_22051013_ex_ctrl_if.ctrl).
module ysyx_22051013_ex_ctrl
    import ysyx_22051013_ex_ctrl_pkg::*;
#(
    parameter int LAT_W = 4,
    parameter int XLEN  = YSYX_XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22051013_ex_ctrl_if.ctrl  bus
);

    ex_state_e        state_q;
    ex_state_e        state_d;
    logic             xfer;
    logic             redirect;
    logic             cnt_zero;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  op1_q;
    logic [XLEN-1:0]  op2_q;
    logic [SEL_W-1:0] sel_q;
    logic             jump_q;
    logic [XLEN-1:0]  res_q;
    logic [XLEN-1:0]  rpc_q;
    logic             redir_q;

    // Redirect only in the first DONE cycle: redir_q is cleared after one DONE cycle.
    assign redirect = (state_q == ST_DONE) && redir_q;

    // A redirect cycle refuses the offered op, since it is on the wrong path.
    assign bus.id_ready_o = !rst &&
                            ((state_q == ST_IDLE) ||
                             ((state_q == ST_DONE) && bus.wb_ready_i && !redirect));
    assign xfer = bus.id_valid_i && bus.id_ready_o;

    ysyx_22051013_ex_lat_cnt #(
        .LAT_W (LAT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .load_val (bus.id_lat_i),
        .dec      (state_q == ST_EXEC),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (xfer) state_d = ST_EXEC;
            ST_EXEC: if (cnt_zero) state_d = ST_DONE;
            ST_DONE: begin
                if (xfer) begin
                    state_d = ST_EXEC;
                end else if (bus.wb_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= '0;
            jump_q  <= 1'b0;
            res_q   <= '0;
            rpc_q   <= '0;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                pc_q   <= bus.id_pc_i;
                op1_q  <= bus.id_op1_i;
                op2_q  <= bus.id_op2_i;
                sel_q  <= bus.id_alu_sel_i;
                jump_q <= bus.id_jump_i;
            end
            // Sample the combinational ALU outputs on the last EXEC cycle.
            if ((state_q == ST_EXEC) && cnt_zero) begin
                res_q   <= bus.alu_res_i;
                rpc_q   <= bus.alu_jump_pc_i;
                redir_q <= bus.alu_pcsrc_i;
            end else if (state_q == ST_DONE) begin
                redir_q <= 1'b0;
            end
        end
    end

    assign bus.alu_pc_o      = pc_q;
    assign bus.alu_op1_o     = op1_q;
    assign bus.alu_op2_o     = op2_q;
    assign bus.alu_sel_o     = sel_q;
    assign bus.alu_jump_o    = jump_q;
    assign bus.wb_valid_o    = (state_q == ST_DONE);
    assign bus.wb_res_o      = res_q;
    assign bus.redirect_o    = redirect;
    assign bus.redirect_pc_o = redirect ? rpc_q : '0;
    assign bus.busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22051013_ex_ctrl.sv
// Testbench for ysyx_22051013_ex_ctrl: table vectors, directed corner sequences, random traffic vs. transaction model.
// Latency: n/a.
// Backpressure: wb_ready_i driven by stimulus.
module tb_ysyx_22051013_ex_ctrl;
    import ysyx_22051013_ex_ctrl_pkg::*;

    localparam int LAT_W = 4;
    localparam int XLEN  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22051013_ex_ctrl_if #(.LAT_W(LAT_W), .XLEN(XLEN)) bus ();

    ysyx_22051013_ex_ctrl #(.LAT_W(LAT_W), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU stub
    function automatic logic [XLEN-1:0] alu_ref(input logic [SEL_W-1:0] sel,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (sel)
            SEL_ADD: r = a + b;
            SEL_SUB: r = a - b;
            SEL_AND: r = a & b;
            SEL_OR:  r = a | b;
            SEL_XOR: r = a ^ b;
            SEL_SLL: r = a << b[5:0];
            SEL_LUI: r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign bus.alu_res_i     = alu_ref(bus.alu_sel_o, bus.alu_op1_o, bus.alu_op2_o);
    assign bus.alu_pcsrc_i   = bus.alu_jump_o;
    assign bus.alu_jump_pc_i = bus.alu_pc_o + bus.alu_op2_o;

    typedef struct {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [SEL_W-1:0] sel;
        logic             jump;
        logic [LAT_W-1:0] lat;
        logic             wb_ready;
        logic             rst;
    } in_t;

    typedef struct {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [SEL_W-1:0] sel;
        logic             jump;
        logic [LAT_W-1:0] lat;
        logic [XLEN-1:0]  exp_res;
        logic             exp_redir;
        logic [XLEN-1:0]  exp_rpc;
    } vec_t;

    int checks;
    int failures;
    int cyc;

    // Transaction model: at most one op in flight, result due at a known cycle.
    bit              have_op;
    int              done_at;
    logic [XLEN-1:0] m_res;
    logic [XLEN-1:0] m_rpc;
    bit              m_jump;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic in_t rand_op();
        in_t r;
        r.valid    = 1'b1;
        r.pc       = {$urandom, $urandom};
        r.op1      = {$urandom, $urandom};
        r.op2      = {$urandom, $urandom};
        r.sel      = SEL_W'(8'd1 << $urandom_range(0, 7));  // 7 selects all-zero
        r.jump     = ($urandom_range(0, 3) == 0);
        r.lat      = ($urandom_range(0, 9) == 0) ? LAT_W'(15) : LAT_W'($urandom_range(0, 3));
        r.wb_ready = 1'b1;
        r.rst      = 1'b0;
        return r;
    endfunction

    function automatic in_t idle_in();
        in_t r;
        r = rand_op();
        r.valid = 1'b0;
        return r;
    endfunction

    task automatic model_step(input in_t st);
        bit v;
        bit rd;
        bit rdy;
        v   = have_op && (cyc >= done_at);
        rd  = v && (cyc == done_at) && m_jump;
        rdy = !st.rst && (!have_op || (v && st.wb_ready && !rd));
        chk("m_id_ready", 64'(bus.id_ready_o), 64'(rdy));
        chk("m_wb_valid", 64'(bus.wb_valid_o), 64'(v));
        chk("m_busy", 64'(bus.busy_o), 64'(have_op));
        chk("m_redirect", 64'(bus.redirect_o), 64'(rd));
        chk("m_redirect_pc", bus.redirect_pc_o, rd ? m_rpc : 64'd0);
        if (v) chk("m_wb_res", bus.wb_res_o, m_res);
        if (st.rst) begin
            have_op = 1'b0;
        end else begin
            if (v && st.wb_ready) have_op = 1'b0;
            if (rdy && st.valid) begin
                have_op = 1'b1;
                done_at = cyc + int'(st.lat) + 2;
                m_res   = alu_ref(st.sel, st.op1, st.op2);
                m_jump  = st.jump;
                m_rpc   = st.pc + st.op2;
            end
        end
    endtask

    // One clock cycle: drive after the rising edge, check on the falling edge.
    task automatic tick(input in_t st);
        @(posedge clk);
        #1;
        rst              = st.rst;
        bus.id_valid_i   = st.valid;
        bus.id_pc_i      = st.pc;
        bus.id_op1_i     = st.op1;
        bus.id_op2_i     = st.op2;
        bus.id_alu_sel_i = st.sel;
        bus.id_jump_i    = st.jump;
        bus.id_lat_i     = st.lat;
        bus.wb_ready_i   = st.wb_ready;
        @(negedge clk);
        model_step(st);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) tick(idle_in());
    endtask

    vec_t vecs[8];

    initial begin
        in_t st;
        in_t ops[3];
        int  n;
        int  busy_n;
        int  accepted;
        int  results;
        int  gap;
        bit  started;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        have_op  = 1'b0;
        done_at  = 0;
        m_res    = '0;
        m_rpc    = '0;
        m_jump   = 1'b0;

        vecs[0] = '{64'h1000, 64'd5, 64'd7, SEL_ADD, 1'b0, 4'd0, 64'd12, 1'b0, 64'd0};
        vecs[1] = '{64'h1004, 64'd20, 64'd8, SEL_SUB, 1'b0, 4'd3, 64'd12, 1'b0, 64'd0};
        vecs[2] = '{64'h1008, 64'hF0, 64'h3C, SEL_AND, 1'b0, 4'd1, 64'h30, 1'b0, 64'd0};
        vecs[3] = '{64'h100C, 64'hF0, 64'h0F, SEL_OR, 1'b0, 4'd2, 64'hFF, 1'b0, 64'd0};
        vecs[4] = '{64'h1010, 64'hFF, 64'h0F, SEL_XOR, 1'b0, 4'd0, 64'hF0, 1'b0, 64'd0};
        vecs[5] = '{64'h1014, 64'd1, 64'd4, SEL_SLL, 1'b0, 4'd15, 64'd16, 1'b0, 64'd0};
        vecs[6] = '{64'h1018, 64'h1234, 64'h5678, 7'd0, 1'b0, 4'd0, 64'd0, 1'b0, 64'd0};
        vecs[7] = '{64'h8000_0000, 64'h8000_0000, 64'h10, SEL_ADD, 1'b1, 4'd0,
                    64'h8000_0010, 1'b1, 64'h8000_0010};

        // Reset state
        rst              = 1'b1;
        bus.id_valid_i   = 1'b0;
        bus.id_pc_i      = '0;
        bus.id_op1_i     = '0;
        bus.id_op2_i     = '0;
        bus.id_alu_sel_i = '0;
        bus.id_jump_i    = 1'b0;
        bus.id_lat_i     = '0;
        bus.wb_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_id_ready", 64'(bus.id_ready_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rst_redirect", 64'(bus.redirect_o), 64'd0);
        chk("rst_alu_op1", bus.alu_op1_o, 64'd0);
        chk("rst_wb_res", bus.wb_res_o, 64'd0);
        tick(idle_in());
        chk("rst_release_ready", 64'(bus.id_ready_o), 64'd1);

        // Table-driven single ops from IDLE
        for (int i = 0; i < 8; i++) begin
            st          = idle_in();
            st.valid    = 1'b1;
            st.pc       = vecs[i].pc;
            st.op1      = vecs[i].op1;
            st.op2      = vecs[i].op2;
            st.sel      = vecs[i].sel;
            st.jump     = vecs[i].jump;
            st.lat      = vecs[i].lat;
            tick(st);
            chk("tbl_accept", 64'(bus.id_ready_o), 64'd1);
            n      = 0;
            busy_n = 0;
            do begin
                tick(idle_in());
                n++;
                if (bus.busy_o) busy_n++;
            end while (!bus.wb_valid_o && n < 40);
            chk("tbl_latency", 64'(n), 64'(vecs[i].lat) + 64'd2);
            chk("tbl_wb_res", bus.wb_res_o, vecs[i].exp_res);
            chk("tbl_redirect", 64'(bus.redirect_o), 64'(vecs[i].exp_redir));
            chk("tbl_redirect_pc", bus.redirect_pc_o, vecs[i].exp_rpc);
            chk("tbl_alu_pc_hold", bus.alu_pc_o, vecs[i].pc);
            chk("tbl_alu_op1_hold", bus.alu_op1_o, vecs[i].op1);
            chk("tbl_alu_sel_hold", 64'(bus.alu_sel_o), 64'(vecs[i].sel));
            tick(idle_in());
            chk("tbl_busy_cycles", 64'(busy_n), 64'(vecs[i].lat) + 64'd2);
            chk("tbl_idle_after", 64'(bus.busy_o), 64'd0);
            chk("tbl_redirect_drop", 64'(bus.redirect_o), 64'd0);
        end

        // Backpressure: result held for 4 stalled DONE cycles, pending op waits
        st       = idle_in();
        st.valid = 1'b1;
        st.op1   = 64'd100;
        st.op2   = 64'd23;
        st.sel   = SEL_ADD;
        st.jump  = 1'b0;
        st.lat   = '0;
        tick(st);
        st          = rand_op();
        st.jump     = 1'b0;
        st.lat      = '0;
        st.wb_ready = 1'b0;
        tick(st);
        for (int k = 0; k < 4; k++) begin
            tick(st);
            chk("bp_wb_valid", 64'(bus.wb_valid_o), 64'd1);
            chk("bp_wb_res", bus.wb_res_o, 64'd123);
            chk("bp_id_ready", 64'(bus.id_ready_o), 64'd0);
        end
        st.wb_ready = 1'b1;
        tick(st);
        chk("bp_release_ready", 64'(bus.id_ready_o), 64'd1);
        chk("bp_release_res", bus.wb_res_o, 64'd123);
        drain(3);

        // Jump: one-cycle redirect, concurrent op refused
        st       = idle_in();
        st.valid = 1'b1;
        st.pc    = 64'h8000_0000;
        st.op1   = 64'd0;
        st.op2   = 64'h10;
        st.sel   = SEL_ADD;
        st.jump  = 1'b1;
        st.lat   = '0;
        tick(st);
        st      = rand_op();
        st.jump = 1'b0;
        st.lat  = '0;
        tick(st);
        tick(st);
        chk("jmp_redirect", 64'(bus.redirect_o), 64'd1);
        chk("jmp_redirect_pc", bus.redirect_pc_o, 64'h8000_0010);
        chk("jmp_refuse", 64'(bus.id_ready_o), 64'd0);
        tick(st);
        chk("jmp_redirect_once", 64'(bus.redirect_o), 64'd0);
        chk("jmp_redirect_pc_zero", bus.redirect_pc_o, 64'd0);
        chk("jmp_idle", 64'(bus.busy_o), 64'd0);
        drain(3);

        // Back-to-back: three single-cycle ops, no IDLE between them
        for (int k = 0; k < 3; k++) begin
            ops[k]      = rand_op();
            ops[k].jump = 1'b0;
            ops[k].lat  = '0;
        end
        accepted = 0;
        results  = 0;
        gap      = 0;
        started  = 1'b0;
        for (int k = 0; k < 20 && results < 3; k++) begin
            st = (accepted < 3) ? ops[accepted] : idle_in();
            tick(st);
            if (bus.wb_valid_o) results++;
            if (started && !bus.busy_o) gap++;
            if (bus.id_ready_o && st.valid) begin
                accepted++;
                started = 1'b1;
            end
        end
        chk("b2b_results", 64'(results), 64'd3);
        chk("b2b_no_idle", 64'(gap), 64'd0);
        drain(2);

        // Reset during the second EXEC cycle of a lat=5 op
        st      = rand_op();
        st.jump = 1'b1;
        st.lat  = 4'd5;
        tick(st);
        tick(idle_in());
        st     = idle_in();
        st.rst = 1'b1;
        tick(st);
        chk("rmid_id_ready", 64'(bus.id_ready_o), 64'd0);
        tick(idle_in());
        chk("rmid_busy", 64'(bus.busy_o), 64'd0);
        chk("rmid_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rmid_wb_res", bus.wb_res_o, 64'd0);
        chk("rmid_redirect", 64'(bus.redirect_o), 64'd0);
        chk("rmid_redirect_pc", bus.redirect_pc_o, 64'd0);
        chk("rmid_alu_pc", bus.alu_pc_o, 64'd0);
        chk("rmid_alu_op1", bus.alu_op1_o, 64'd0);
        chk("rmid_alu_op2", bus.alu_op2_o, 64'd0);
        chk("rmid_alu_sel", 64'(bus.alu_sel_o), 64'd0);
        chk("rmid_alu_jump", 64'(bus.alu_jump_o), 64'd0);
        chk("rmid_id_ready_after", 64'(bus.id_ready_o), 64'd1);
        for (int k = 0; k < 8; k++) begin
            tick(idle_in());
            chk("rmid_no_wb", 64'(bus.wb_valid_o), 64'd0);
        end

        // Random traffic against the transaction model
        for (int k = 0; k < 500; k++) begin
            st          = ($urandom_range(0, 2) == 0) ? idle_in() : rand_op();
            st.wb_ready = ($urandom_range(0, 3) != 0);
            st.rst      = ($urandom_range(0, 99) == 0);
            tick(st);
        end
        drain(24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
